// File: rtl/reduce_sequencer_pkg.sv
// Shared encodings for the reduce sequencer: stack/ALU command codes, operator
// codes, sequencing modes, FSM states and the operator-to-ALU mapping.
package reduce_sequencer_pkg;

    localparam int SC_N = 2;
    localparam logic [SC_N-1:0] SC_NONE = 2'd0;
    localparam logic [SC_N-1:0] SC_PUSH = 2'd1;
    localparam logic [SC_N-1:0] SC_POP  = 2'd2;

    localparam int AC_N = 3;
    typedef logic [AC_N-1:0] alu_cmd_t;
    localparam alu_cmd_t AC_ADD  = 3'd0;
    localparam alu_cmd_t AC_SUB  = 3'd1;
    localparam alu_cmd_t AC_MUL  = 3'd2;
    localparam alu_cmd_t AC_DIV  = 3'd3;
    localparam alu_cmd_t AC_AND  = 3'd4;
    localparam alu_cmd_t AC_OR   = 3'd5;
    localparam alu_cmd_t AC_XOR  = 3'd6;
    localparam alu_cmd_t AC_PASS = 3'd7;

    localparam int OP_W = 5;
    typedef logic [OP_W-1:0] op_code_t;
    localparam op_code_t OP_ADD    = 5'd1;
    localparam op_code_t OP_SUB    = 5'd2;
    localparam op_code_t OP_MUL    = 5'd3;
    localparam op_code_t OP_DIV    = 5'd4;
    localparam op_code_t OP_AND    = 5'd5;
    localparam op_code_t OP_OR     = 5'd6;
    localparam op_code_t OP_XOR    = 5'd7;
    localparam op_code_t OP_LPAREN = 5'd16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_UNTIL  = 2'd1,
        MODE_DRAIN  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Unknown operators (including parens) fall through to PASS.
    function automatic alu_cmd_t op2alu(input op_code_t op);
        case (op)
            OP_ADD:  return AC_ADD;
            OP_SUB:  return AC_SUB;
            OP_MUL:  return AC_MUL;
            OP_DIV:  return AC_DIV;
            OP_AND:  return AC_AND;
            OP_OR:   return AC_OR;
            OP_XOR:  return AC_XOR;
            default: return AC_PASS;
        endcase
    endfunction

endpackage

// File: rtl/reduce_sequencer.sv
// Multi-cycle reduce sequencer: pops an operator and two operands, runs the
// shared ALU, pushes the result, and repeats according to the latched mode.
module reduce_sequencer
    import reduce_sequencer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int OW    = 5,
    parameter int CNT_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [OW-1:0]    inc_op,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_N-1:0] n_reduced,
    input  logic [DW-1:0]    dt_rdata,
    input  logic             dt_empty,
    output logic [DW-1:0]    dt_wdata,
    output logic [SC_N-1:0]  dt_cmd,
    input  logic [OW-1:0]    op_rdata,
    input  logic             op_empty,
    output logic [SC_N-1:0]  op_cmd,
    output logic [DW-1:0]    al_A,
    output logic [DW-1:0]    al_B,
    output logic [AC_N-1:0]  al_cmd,
    input  logic [DW-1:0]    al_C,
    output logic [OW-1:0]    pr_A,
    output logic [OW-1:0]    pr_B,
    input  logic             pr_res
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [OW-1:0]    inc_q, inc_d;
    logic [OW-1:0]    op_q, op_d;
    logic [DW-1:0]    b_q, b_d;
    logic [DW-1:0]    al_a_q, al_a_d;
    logic [DW-1:0]    al_b_q, al_b_d;
    alu_cmd_t         al_cmd_q, al_cmd_d;
    logic [CNT_N-1:0] cnt_q, cnt_d;
    logic             stop_chk;

    // Normal-completion conditions at CHECK, ahead of the underflow test.
    assign stop_chk = op_empty
                   || (mode_q == MODE_UNTIL && !pr_res)
                   || (mode_q == MODE_DRAIN && op_rdata == OW'(OP_LPAREN));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                if (stop_chk)      state_d = ST_DONE;
                else if (dt_empty) state_d = ST_ERR;
                else               state_d = ST_LOAD_A;
            end
            ST_LOAD_A: state_d = dt_empty ? ST_ERR : ST_EXEC;
            ST_EXEC:   state_d = (mode_q == MODE_SINGLE) ? ST_DONE : ST_CHECK;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        inc_d    = inc_q;
        op_d     = op_q;
        b_d      = b_q;
        al_a_d   = al_a_q;
        al_b_d   = al_b_q;
        al_cmd_d = al_cmd_q;
        cnt_d    = cnt_q;
        dt_cmd   = SC_NONE;
        op_cmd   = SC_NONE;
        dt_wdata = '0;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE) || (state_q == ST_ERR);
        error    = (state_q == ST_ERR);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = (mode == 2'b11) ? MODE_SINGLE : mode_e'(mode);
                    inc_d  = inc_op;
                    cnt_d  = '0;
                end
            end
            ST_CHECK: begin
                if (!stop_chk && !dt_empty) begin
                    op_d   = op_rdata;
                    b_d    = dt_rdata;
                    op_cmd = SC_POP;
                    dt_cmd = SC_POP;
                end
            end
            // ALU operand registers load only here so they hold outside EXEC.
            ST_LOAD_A: begin
                if (!dt_empty) begin
                    al_a_d   = dt_rdata;
                    al_b_d   = b_q;
                    al_cmd_d = op2alu(op_code_t'(op_q));
                    dt_cmd   = SC_POP;
                end
            end
            ST_EXEC: begin
                dt_wdata = al_C;
                dt_cmd   = SC_PUSH;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_N'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_SINGLE;
            inc_q    <= '0;
            op_q     <= '0;
            b_q      <= '0;
            al_a_q   <= '0;
            al_b_q   <= '0;
            al_cmd_q <= '0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            inc_q    <= inc_d;
            op_q     <= op_d;
            b_q      <= b_d;
            al_a_q   <= al_a_d;
            al_b_q   <= al_b_d;
            al_cmd_q <= al_cmd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign n_reduced = cnt_q;
    assign al_A      = al_a_q;
    assign al_B      = al_b_q;
    assign al_cmd    = al_cmd_q;
    assign pr_A      = inc_q;
    assign pr_B      = op_rdata;

endmodule

// File: tb/tb_reduce_sequencer.sv
// Bench for reduce_sequencer: queue-based stacks, behavioural ALU/precedence,
// and a per-request operation model producing the expected cycle trace.
module tb_reduce_sequencer;
    import reduce_sequencer_pkg::*;

    localparam int DW = 32;
    localparam int OW = 5;
    localparam int CNT_N = 4;

    logic clk = 0, rst = 1, start = 0;
    logic [1:0] mode = 0;
    logic [OW-1:0] inc_op = 0;
    logic busy, done, error;
    logic [CNT_N-1:0] n_reduced;
    logic [DW-1:0] dt_rdata = 0, dt_wdata;
    logic dt_empty = 1, op_empty = 1;
    logic [SC_N-1:0] dt_cmd, op_cmd;
    logic [OW-1:0] op_rdata = 0;
    logic [DW-1:0] al_A, al_B, al_C;
    logic [AC_N-1:0] al_cmd;
    logic [OW-1:0] pr_A, pr_B;
    logic pr_res;

    reduce_sequencer #(.DW(DW), .OW(OW), .CNT_N(CNT_N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .inc_op(inc_op),
        .busy(busy), .done(done), .error(error), .n_reduced(n_reduced),
        .dt_rdata(dt_rdata), .dt_empty(dt_empty), .dt_wdata(dt_wdata), .dt_cmd(dt_cmd),
        .op_rdata(op_rdata), .op_empty(op_empty), .op_cmd(op_cmd),
        .al_A(al_A), .al_B(al_B), .al_cmd(al_cmd), .al_C(al_C),
        .pr_A(pr_A), .pr_B(pr_B), .pr_res(pr_res)
    );

    always #5 clk = ~clk;

    function automatic int prec(input logic [OW-1:0] op);
        case (op)
            OP_ADD, OP_SUB: return 1;
            OP_MUL, OP_DIV: return 2;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu(input logic [AC_N-1:0] c, input logic [DW-1:0] a, b);
        case (c)
            AC_ADD:  return a + b;
            AC_SUB:  return a - b;
            AC_MUL:  return a * b;
            AC_DIV:  return (b == 0) ? '0 : a / b;
            AC_AND:  return a & b;
            AC_OR:   return a | b;
            AC_XOR:  return a ^ b;
            default: return a;
        endcase
    endfunction

    function automatic logic [DW-1:0] apply(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? '0 : a / b;
            default: return a;
        endcase
    endfunction

    assign al_C   = alu(al_cmd, al_A, al_B);
    assign pr_res = prec(pr_B) >= prec(pr_A);

    // Stacks: top is the last queue element; commands apply at the clock edge.
    logic [DW-1:0] dstk[$];
    logic [OW-1:0] ostk[$];
    always @(posedge clk) begin
        if (dt_cmd == SC_POP && dstk.size() > 0) void'(dstk.pop_back());
        else if (dt_cmd == SC_PUSH) dstk.push_back(dt_wdata);
        if (op_cmd == SC_POP && ostk.size() > 0) void'(ostk.pop_back());
        dt_empty <= (dstk.size() == 0);
        dt_rdata <= (dstk.size() > 0) ? dstk[dstk.size()-1] : '0;
        op_empty <= (ostk.size() == 0);
        op_rdata <= (ostk.size() > 0) ? ostk[ostk.size()-1] : '0;
    end

    typedef struct packed {
        logic            busy, done, err;
        logic [SC_N-1:0] dtc, opc;
        logic [DW-1:0]   wd;
    } exp_t;

    exp_t expq[$];
    int n_cmp = 0, n_err = 0;
    bit check_en = 0;
    logic [DW-1:0] mdl_d[$];
    logic [OW-1:0] mdl_o[$];
    int mdl_n;

    function automatic exp_t mk(input logic b, dn, er, input logic [SC_N-1:0] dtc, opc,
                                input logic [DW-1:0] wd);
        exp_t e;
        e.busy = b; e.done = dn; e.err = er; e.dtc = dtc; e.opc = opc; e.wd = wd;
        return e;
    endfunction

    // One request at operation level: what happens to the stacks, and when.
    task automatic model(input logic [1:0] md, input logic [OW-1:0] inc);
        logic [DW-1:0] d[$];
        logic [OW-1:0] o[$];
        logic [DW-1:0] a, b, r;
        logic [OW-1:0] op;
        int n;
        d = dstk; o = ostk; n = 0;
        expq.push_back(mk(0, 0, 0, SC_NONE, SC_NONE, 0));
        forever begin
            if (o.size() == 0 || (md == 2'd1 && prec(o[$]) < prec(inc)) ||
                (md == 2'd2 && o[$] == OP_LPAREN)) begin
                expq.push_back(mk(1, 0, 0, SC_NONE, SC_NONE, 0));
                expq.push_back(mk(1, 1, 0, SC_NONE, SC_NONE, 0));
                break;
            end
            if (d.size() == 0) begin
                expq.push_back(mk(1, 0, 0, SC_NONE, SC_NONE, 0));
                expq.push_back(mk(1, 1, 1, SC_NONE, SC_NONE, 0));
                break;
            end
            expq.push_back(mk(1, 0, 0, SC_POP, SC_POP, 0));
            b = d.pop_back(); op = o.pop_back();
            if (d.size() == 0) begin
                expq.push_back(mk(1, 0, 0, SC_NONE, SC_NONE, 0));
                expq.push_back(mk(1, 1, 1, SC_NONE, SC_NONE, 0));
                break;
            end
            expq.push_back(mk(1, 0, 0, SC_POP, SC_NONE, 0));
            a = d.pop_back();
            r = apply(op, a, b);
            d.push_back(r);
            expq.push_back(mk(1, 0, 0, SC_PUSH, SC_NONE, r));
            if (n < 15) n++;
            if (md == 2'd0 || md == 2'd3) begin
                expq.push_back(mk(1, 1, 0, SC_NONE, SC_NONE, 0));
                break;
            end
        end
        mdl_d = d; mdl_o = o; mdl_n = n;
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        a = {busy, done, error, dt_cmd, op_cmd, dt_wdata};
        if (rst) expq.delete();
        else if (check_en) begin
            e = (expq.size() > 0) ? expq.pop_front() : mk(0, 0, 0, SC_NONE, SC_NONE, 0);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL trace @%0t: got busy/done/err/dtc/opc/wd=%h want %h", $time, a, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " dsize"}, 64'(dstk.size()), 64'(mdl_d.size()));
        chk({nm, " osize"}, 64'(ostk.size()), 64'(mdl_o.size()));
        for (int i = 0; i < dstk.size() && i < mdl_d.size(); i++)
            chk({nm, " dval"}, 64'(dstk[i]), 64'(mdl_d[i]));
        chk({nm, " n_reduced"}, 64'(n_reduced), 64'(mdl_n));
    endtask

    task automatic run(input logic [1:0] md, input logic [OW-1:0] inc, input bit extra_start);
        @(posedge clk); #1;
        start = 1; mode = md; inc_op = inc;
        model(md, inc);
        @(posedge clk); #1;
        start = 0;
        if (extra_start) begin
            @(posedge clk); #1;
            start = 1; mode = 2'd2;
            @(posedge clk); #1;
            start = 0;
        end
        for (int i = 0; i < 200 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: %0d trace entries left, want 0", expq.size());
            expq.delete();
        end
        @(posedge clk); #1;
        chk_model("model");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst busy", 64'(busy), 0);
        chk("rst done", 64'(done), 0);
        chk("rst error", 64'(error), 0);
        chk("rst n_reduced", 64'(n_reduced), 0);
        chk("rst dt_cmd", 64'(dt_cmd), 64'(SC_NONE));
        chk("rst op_cmd", 64'(op_cmd), 64'(SC_NONE));
        chk("rst dt_wdata", 64'(dt_wdata), 0);
        chk("rst al_A/B/cmd", {al_A, al_B} | 64'(al_cmd), 0);
        chk("rst pr_A", 64'(pr_A), 0);
        check_en = 1;

        // SINGLE 7-2
        dstk = '{32'd7, 32'd2}; ostk = '{OP_SUB}; @(posedge clk);
        run(2'd0, OP_ADD, 0);
        chk("single dsize", 64'(dstk.size()), 1);
        chk("single result", 64'(dstk[0]), 5);
        chk("single n", 64'(n_reduced), 1);

        // UNTIL with '+' incoming, plus an ignored start while busy
        dstk = '{32'd1, 32'd2, 32'd3}; ostk = '{OP_ADD, OP_MUL}; @(posedge clk);
        run(2'd1, OP_ADD, 1);
        chk("until result", 64'(dstk[0]), 7);
        chk("until osize", 64'(ostk.size()), 0);
        chk("until n", 64'(n_reduced), 2);

        // UNTIL stopping on lower-precedence top
        dstk = '{32'd8, 32'd3, 32'd4}; ostk = '{OP_SUB, OP_ADD}; @(posedge clk);
        run(2'd1, OP_MUL, 0);
        chk("until-stop n", 64'(n_reduced), 0);

        // DRAIN stops at paren
        dstk = '{32'd4, 32'd5, 32'd6}; ostk = '{OP_ADD, OP_LPAREN, OP_MUL}; @(posedge clk);
        run(2'd2, OP_ADD, 0);
        chk("drain top", 64'(dstk[1]), 30);
        chk("drain paren kept", 64'(ostk[1]), 64'(OP_LPAREN));
        chk("drain n", 64'(n_reduced), 1);

        // Underflow after one operand
        dstk = '{32'd9}; ostk = '{OP_ADD}; @(posedge clk);
        run(2'd0, OP_ADD, 0);
        chk("err dsize", 64'(dstk.size()), 0);
        chk("err osize", 64'(ostk.size()), 0);

        // Underflow with no operands: nothing popped
        ostk = '{OP_MUL}; @(posedge clk);
        run(2'd2, OP_ADD, 0);
        chk("err0 osize", 64'(ostk.size()), 1);

        // Empty operator stack in every mode
        dstk = '{32'd3}; ostk.delete(); @(posedge clk);
        for (int m = 0; m < 4; m++) run(2'(m), OP_ADD, 0);
        chk("empty data kept", 64'(dstk[0]), 3);

        // Counter saturation: 16 reductions
        dstk.delete(); ostk.delete();
        for (int i = 0; i < 17; i++) dstk.push_back(32'd1);
        for (int i = 0; i < 16; i++) ostk.push_back(OP_ADD);
        @(posedge clk);
        run(2'd2, OP_ADD, 0);
        chk("sat result", 64'(dstk[0]), 17);
        chk("sat n", 64'(n_reduced), 15);

        // Reset during LOAD_A
        dstk = '{32'd7, 32'd2}; ostk = '{OP_SUB}; @(posedge clk);
        @(posedge clk); #1;
        start = 1; mode = 2'd0; model(2'd0, OP_ADD);
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst busy", 64'(busy), 0);
        chk("midrst dt_cmd", 64'(dt_cmd), 64'(SC_NONE));
        chk("midrst n", 64'(n_reduced), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst no push", 64'((dstk.size() > 0) && (dstk[dstk.size()-1] == 32'd5)), 0);

        // Normal start after reset
        dstk = '{32'd7, 32'd2}; ostk = '{OP_SUB}; @(posedge clk);
        run(2'd0, OP_ADD, 0);
        chk("post-rst result", 64'(dstk[0]), 5);

        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reduce_sequencer.md
Name: reduce_sequencer

Overview:
- Multi-cycle sequencer for the expression-evaluation datapath: data stack, operator stack, ALU and precedence ROM.
- On request it pops an operator and two operands, runs the ALU and pushes the result. It repeats per the selected mode: single step, reduce-while-precedence, or drain to paren/empty.
- Sits between the main controller and the shared stack/ALU resources. The controller hands it the stacks and ALU while busy is high.

Parameters:
DW, 32, data word width (matches data stack and ALU width)
OW, 5, operator code width (matches operator stack width)
CNT_N, 4, width of reduction counter

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  00 SINGLE, 01 UNTIL, 10 DRAIN, 11 treated as SINGLE
inc_op  in  OW  incoming operator, used as precedence left operand in UNTIL mode
busy  out  1  high from cycle after accepted start until DONE/ERR exit
done  out  1  one-cycle pulse on completion (also on error)
error  out  1  one-cycle pulse coincident with done when operand underflow occurs
n_reduced  out  CNT_N  reductions performed by last request, saturating
dt_rdata  in  DW  data stack top, valid combinationally
dt_empty  in  1  data stack empty
dt_wdata  out  DW  data stack push value
dt_cmd  out  SC_N  data stack command (none/push/pop, stack interface constants)
op_rdata  in  OW  operator stack top
op_empty  in  1  operator stack empty
op_cmd  out  SC_N  operator stack command
al_A  out  DW  ALU left operand
al_B  out  DW  ALU right operand
al_cmd  out  AC_N  ALU command
al_C  in  DW  ALU result (combinational)
pr_A  out  OW  precedence left operand (= latched inc_op)
pr_B  out  OW  precedence right operand (= op_rdata)
pr_res  in  1  1 = reduce (top operator binds at least as tightly)

Behaviour:
- Reset state: IDLE. All outputs 0 and both stack commands NONE on the cycle after Reset is sampled. Reset mid-sequence abandons the operation and issues no partial push.
- Stack commands take effect at the clock edge. At most one command per stack per cycle.
- IDLE: when start=1, latch mode and inc_op, clear n_reduced, go to CHECK. busy=0. A start while busy is ignored.
- CHECK: evaluate stop conditions in priority order:
  - op_empty -> DONE.
  - UNTIL mode with pr_res=0 -> DONE.
  - DRAIN mode with op_rdata==OP_LPAREN -> DONE. The paren is not popped.
  - dt_empty -> ERR.
  - Otherwise: op_r<=op_rdata, B_r<=dt_rdata, op_cmd=POP, dt_cmd=POP, go to LOAD_A.
- LOAD_A: if dt_empty -> ERR, with the operator and B already consumed. Otherwise A_r<=dt_rdata, dt_cmd=POP, go to EXEC.
- EXEC: drive al_A=A_r, al_B=B_r, al_cmd=op2alu(op_r). Same cycle: dt_wdata=al_C, dt_cmd=PUSH. n_reduced increments, saturating at all-ones. Next state is DONE if mode is SINGLE, else CHECK.
- Latency: 3 cycles per reduction (CHECK, LOAD_A, EXEC), plus 1 cycle for DONE.
- DONE: done=1 for one cycle, go to IDLE.
- ERR: done=1 and error=1 for one cycle, go to IDLE.
- busy is high in CHECK, LOAD_A, EXEC, DONE and ERR.
- SINGLE with op_empty at CHECK: done with n_reduced=0, no stack activity.
- Operand order: A is the deeper element, B is the top. For example, 7 then 2 pushed with '-' gives 5.
- ALU overflow and wrap follow the ALU. The sequencer does not inspect the result.
- Outside EXEC, al_A/al_B/al_cmd hold their last values. dt_wdata=0 when not pushing.

Decomposition:
- Shared package/header: state encoding; mode constants (MODE_SINGLE, MODE_UNTIL, MODE_DRAIN); OP_LPAREN; the op2alu operator-to-ALU-command mapping function. Stack command constants come from the stack interface header.
- No sub-module is needed. The counter and FSM live in a single module.

Test Plan:
- Data stack [7,2] (2 on top), op stack ['-'], SINGLE -> one pop/pop/push sequence; data stack [5]; done after 4 cycles; n_reduced=1; error=0.
- Data [1,2,3], ops ['+','*'] ('*' on top), inc_op='+', UNTIL -> 2*3=6, then 1+6=7; op stack empties; n_reduced=2; done.
- Data [4,5,6], ops ['+','(','*'], DRAIN -> 5*6=30 pushed; stops with '(' on top; data [4,30]; n_reduced=1.
- Data [9], ops ['+'], SINGLE -> ERR after LOAD_A; done=1 and error=1 same cycle; both stacks empty; no push.
- Op stack empty, start in each mode -> done two cycles after start; n_reduced=0; no stack commands issued.
- Reset asserted during LOAD_A -> next cycle IDLE, busy=0, dt_cmd=NONE; no push occurs; a later start is accepted normally.
